// File: rtl/scanline_pingpong_buffer_pkg.sv
// Shared definitions for the scanline ping-pong buffer:
// line geometry, the pixel layout and the write-side FSM states.
package scanline_pingpong_buffer_pkg;

    localparam int PIX_W         = 6;
    localparam int LINE_PIXELS   = 848;
    localparam int ADDR_W        = 10;
    localparam int VISIBLE_LINES = 480;
    localparam int LINE_IDX_W    = 9;

    // RRGGBB pixel: red in [5:4], green in [3:2], blue in [1:0]
    typedef struct packed {
        logic [1:0] r;
        logic [1:0] g;
        logic [1:0] b;
    } rrggbb_t;

    // Write side: request a line, accept its pixels, then hold it until swapped in
    typedef enum logic [1:0] {
        REQ  = 2'd0,
        FILL = 2'd1,
        FULL = 2'd2
    } wr_state_t;

endpackage

// File: rtl/scanline_pingpong_buffer_bank_ram.sv
// One scanline bank: single write port, registered read port.
// Contents are never reset so the array maps onto block RAM.
module scanline_bank_ram #(
    parameter int DEPTH  = 848,
    parameter int PIX_W  = 6,
    parameter int ADDR_W = 10
) (
    input  logic              CLK,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [PIX_W-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [PIX_W-1:0]  rdata
);

    logic [PIX_W-1:0] mem [DEPTH];

    // Write-first is irrelevant here: the top never reads and writes one bank together
    always_ff @(posedge CLK) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/scanline_pingpong_buffer.sv
// Double-buffered scanline store between the pixel producer and the
// VGA display stage. The producer fills the back bank over valid/ready,
// the display reads the front bank by pixel index, and the banks swap on
// the display's line_start pulse once the back bank holds a full line.
// Optional: define SCANLINE_UNDERRUN_CNT_EN to add the saturating
// underrun_cnt[7:0] output (refused swaps since the last frame_start).
module scanline_pingpong_buffer #(
    parameter int LINE_PIXELS = scanline_pingpong_buffer_pkg::LINE_PIXELS,
    parameter int PIX_W       = scanline_pingpong_buffer_pkg::PIX_W,
    parameter int ADDR_W      = scanline_pingpong_buffer_pkg::ADDR_W
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              line_start,
    input  logic              frame_start,
    input  logic              wr_valid,
    input  logic [PIX_W-1:0]  wr_data,
    output logic              wr_ready,
    output logic              fill_req,
    output logic [8:0]        fill_line,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [PIX_W-1:0]  rd_data,
`ifdef SCANLINE_UNDERRUN_CNT_EN
    output logic [7:0]        underrun_cnt,
`endif
    output logic              underrun
);

    import scanline_pingpong_buffer_pkg::*;

    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(LINE_PIXELS - 1);
    localparam logic [8:0]        LAST_LINE = 9'(VISIBLE_LINES - 1);

    function automatic logic [8:0] next_line(input logic [8:0] cur);
        return (cur == LAST_LINE) ? 9'd0 : cur + 9'd1;
    endfunction

    wr_state_t         state;
    logic [ADDR_W-1:0] wr_ptr;
    logic              front_sel;
    logic              front_valid;
    logic              frame_pend;

    logic              xfer;
    logic              last_beat;
    logic              swap;
    logic              refused;

    logic              we0;
    logic              we1;
    logic [PIX_W-1:0]  q0;
    logic [PIX_W-1:0]  q1;
    logic              rd_vld_p1;
    logic              rd_sel_p1;

    // wr_ready is high exactly while in FILL, so it doubles as the accept qualifier
    assign xfer      = wr_valid && wr_ready;
    assign last_beat = xfer && (wr_ptr == LAST_IDX);
    assign swap      = line_start && ((state == FULL) || last_beat);
    assign refused   = line_start && !swap;

    // The back bank is the one not selected for display
    assign we0 = xfer &&  front_sel;
    assign we1 = xfer && !front_sel;

    scanline_bank_ram #(
        .DEPTH  (LINE_PIXELS),
        .PIX_W  (PIX_W),
        .ADDR_W (ADDR_W)
    ) u_bank0 (
        .CLK   (CLK),
        .we    (we0),
        .waddr (wr_ptr),
        .wdata (wr_data),
        .raddr (rd_addr),
        .rdata (q0)
    );

    scanline_bank_ram #(
        .DEPTH  (LINE_PIXELS),
        .PIX_W  (PIX_W),
        .ADDR_W (ADDR_W)
    ) u_bank1 (
        .CLK   (CLK),
        .we    (we1),
        .waddr (wr_ptr),
        .wdata (wr_data),
        .raddr (rd_addr),
        .rdata (q1)
    );

    // Write FSM: one-cycle fill request, accept a full line, then wait for the swap
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= REQ;
            wr_ptr   <= '0;
            wr_ready <= 1'b0;
            fill_req <= 1'b0;
        end else begin
            fill_req <= 1'b0;
            case (state)
                REQ: begin
                    fill_req <= 1'b1;
                    wr_ready <= 1'b1;
                    state    <= FILL;
                end
                FILL: begin
                    if (xfer) begin
                        if (last_beat) begin
                            wr_ptr   <= '0;
                            wr_ready <= 1'b0;
                            state    <= swap ? REQ : FULL;
                        end else begin
                            wr_ptr <= wr_ptr + ADDR_W'(1);
                        end
                    end
                end
                FULL: begin
                    if (line_start) begin
                        state <= REQ;
                    end
                end
                default: begin
                    state    <= REQ;
                    wr_ready <= 1'b0;
                end
            endcase
        end
    end

    // Bank swap, requested line index and sticky underrun flag
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            front_sel   <= 1'b0;
            front_valid <= 1'b0;
            fill_line   <= '0;
            frame_pend  <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            if (swap) begin
                front_sel   <= ~front_sel;
                front_valid <= 1'b1;
                fill_line   <= (frame_start || frame_pend) ? 9'd0 : next_line(fill_line);
                frame_pend  <= 1'b0;
            end else if (frame_start) begin
                // Frame began while the back bank was short; restart at line 0 on the next swap
                frame_pend <= 1'b1;
            end

            if (frame_start) begin
                underrun <= refused;
            end else if (refused) begin
                underrun <= 1'b1;
            end
        end
    end

`ifdef SCANLINE_UNDERRUN_CNT_EN
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Saturating count of refused swaps, cleared at frame start
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            underrun_cnt <= '0;
        end else if (frame_start) begin
            underrun_cnt <= refused ? 8'd1 : 8'd0;
        end else if (refused) begin
            underrun_cnt <= sat_inc(underrun_cnt);
        end
    end
`endif

    // ---- p0 -> p1: bank read and qualifier capture ----
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rd_vld_p1 <= 1'b0;
            rd_sel_p1 <= 1'b0;
        end else begin
            rd_vld_p1 <= front_valid && (rd_addr <= LAST_IDX);
            rd_sel_p1 <= front_sel;
        end
    end

    assign rd_data = rd_vld_p1 ? (rd_sel_p1 ? q1 : q0) : '0;

endmodule

// File: tb/tb_scanline_pingpong_buffer.sv
// Directed bench for scanline_pingpong_buffer: reset, fill and swap,
// underrun, last beat coinciding with line_start, out-of-range reads,
// frame_start handling and reset in the middle of a fill.
module tb_scanline_pingpong_buffer;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b1;
    logic       line_start = 1'b0;
    logic       frame_start = 1'b0;
    logic       wr_valid = 1'b0;
    logic [5:0] wr_data = '0;
    logic       wr_ready;
    logic       fill_req;
    logic [8:0] fill_line;
    logic [9:0] rd_addr = '0;
    logic [5:0] rd_data;
    logic       underrun;
`ifdef SCANLINE_UNDERRUN_CNT_EN
    logic [7:0] underrun_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 CLK = ~CLK;

    scanline_pingpong_buffer dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .line_start   (line_start),
        .frame_start  (frame_start),
        .wr_valid     (wr_valid),
        .wr_data      (wr_data),
        .wr_ready     (wr_ready),
        .fill_req     (fill_req),
        .fill_line    (fill_line),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
`ifdef SCANLINE_UNDERRUN_CNT_EN
        .underrun_cnt (underrun_cnt),
`endif
        .underrun     (underrun)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Stream pixels first..first+count-1 with value (index + off) mod 64
    task automatic push(input int first, input int count, input int off);
        for (int i = first; i < first + count; i++) begin
            wr_valid = 1'b1;
            wr_data  = 6'((i + off) % 64);
            tick();
        end
        wr_valid = 1'b0;
    endtask

    task automatic test_reset();
        #3 RST_N = 1'b0;
        tick(); tick(); tick();
        n_cmp++; if (wr_ready !== 1'b0) begin n_bad++; $display("FAIL rst_wr_ready: got %b want 0", wr_ready); end
        n_cmp++; if (fill_req !== 1'b0) begin n_bad++; $display("FAIL rst_fill_req: got %b want 0", fill_req); end
        n_cmp++; if (fill_line !== 9'd0) begin n_bad++; $display("FAIL rst_fill_line: got %0d want 0", fill_line); end
        n_cmp++; if (rd_data !== 6'd0) begin n_bad++; $display("FAIL rst_rd_data: got %0d want 0", rd_data); end
        n_cmp++; if (underrun !== 1'b0) begin n_bad++; $display("FAIL rst_underrun: got %b want 0", underrun); end
        RST_N = 1'b1;
        tick();
        n_cmp++; if (fill_req !== 1'b1) begin n_bad++; $display("FAIL first_fill_req: got %b want 1", fill_req); end
        n_cmp++; if (fill_line !== 9'd0) begin n_bad++; $display("FAIL first_fill_line: got %0d want 0", fill_line); end
        n_cmp++; if (wr_ready !== 1'b1) begin n_bad++; $display("FAIL first_wr_ready: got %b want 1", wr_ready); end
        rd_addr = 10'd5;
        tick();
        n_cmp++; if (fill_req !== 1'b0) begin n_bad++; $display("FAIL fill_req_one_cycle: got %b want 0", fill_req); end
        n_cmp++; if (rd_data !== 6'd0) begin n_bad++; $display("FAIL black_before_swap_5: got %0d want 0", rd_data); end
        rd_addr = 10'd847;
        tick();
        n_cmp++; if (rd_data !== 6'd0) begin n_bad++; $display("FAIL black_before_swap_847: got %0d want 0", rd_data); end
    endtask

    task automatic test_fill_swap();
        push(0, 848, 0);
        n_cmp++; if (wr_ready !== 1'b0) begin n_bad++; $display("FAIL full_wr_ready: got %b want 0", wr_ready); end
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        rd_addr = 10'd5;
        tick();
        n_cmp++; if (rd_data !== 6'd5) begin n_bad++; $display("FAIL swap_rd5: got %0d want 5", rd_data); end
        n_cmp++; if (fill_req !== 1'b1) begin n_bad++; $display("FAIL swap_fill_req: got %b want 1", fill_req); end
        n_cmp++; if (fill_line !== 9'd1) begin n_bad++; $display("FAIL swap_fill_line: got %0d want 1", fill_line); end
        rd_addr = 10'd847;
        tick();
        n_cmp++; if (rd_data !== 6'd15) begin n_bad++; $display("FAIL swap_rd847: got %0d want 15", rd_data); end
    endtask

    task automatic test_underrun();
        push(0, 400, 7);
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        n_cmp++; if (underrun !== 1'b1) begin n_bad++; $display("FAIL underrun_set: got %b want 1", underrun); end
        n_cmp++; if (wr_ready !== 1'b1) begin n_bad++; $display("FAIL underrun_wr_ready: got %b want 1", wr_ready); end
`ifdef SCANLINE_UNDERRUN_CNT_EN
        n_cmp++; if (underrun_cnt !== 8'd1) begin n_bad++; $display("FAIL underrun_cnt1: got %0d want 1", underrun_cnt); end
`endif
        rd_addr = 10'd5;
        tick();
        n_cmp++; if (rd_data !== 6'd5) begin n_bad++; $display("FAIL underrun_old_line: got %0d want 5", rd_data); end
        push(400, 448, 7);
        n_cmp++; if (wr_ready !== 1'b0) begin n_bad++; $display("FAIL underrun_completed: got %b want 0", wr_ready); end
        n_cmp++; if (fill_line !== 9'd1) begin n_bad++; $display("FAIL underrun_no_advance: got %0d want 1", fill_line); end
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        rd_addr = 10'd5;
        tick();
        n_cmp++; if (rd_data !== 6'd12) begin n_bad++; $display("FAIL partial_kept_rd5: got %0d want 12", rd_data); end
        n_cmp++; if (fill_line !== 9'd2) begin n_bad++; $display("FAIL underrun_next_line: got %0d want 2", fill_line); end
        rd_addr = 10'd420;
        tick();
        n_cmp++; if (rd_data !== 6'd43) begin n_bad++; $display("FAIL partial_kept_rd420: got %0d want 43", rd_data); end
    endtask

    task automatic test_back_to_back();
        push(0, 847, 20);
        wr_valid   = 1'b1;
        wr_data    = 6'((847 + 20) % 64);
        line_start = 1'b1;
        tick();
        wr_valid   = 1'b0;
        line_start = 1'b0;
        rd_addr    = 10'd847;
        tick();
        n_cmp++; if (rd_data !== 6'd35) begin n_bad++; $display("FAIL b2b_rd847: got %0d want 35", rd_data); end
        n_cmp++; if (fill_req !== 1'b1) begin n_bad++; $display("FAIL b2b_fill_req: got %b want 1", fill_req); end
        n_cmp++; if (fill_line !== 9'd3) begin n_bad++; $display("FAIL b2b_fill_line: got %0d want 3", fill_line); end
    endtask

    task automatic test_frame_start();
        rd_addr = 10'd900;
        tick();
        n_cmp++; if (rd_data !== 6'd0) begin n_bad++; $display("FAIL rd_out_of_range: got %0d want 0", rd_data); end
        rd_addr = 10'd0;
        tick();
        n_cmp++; if (rd_data !== 6'd20) begin n_bad++; $display("FAIL rd_addr0: got %0d want 20", rd_data); end
        push(0, 848, 30);
        line_start  = 1'b1;
        frame_start = 1'b1;
        tick();
        line_start  = 1'b0;
        frame_start = 1'b0;
        n_cmp++; if (underrun !== 1'b0) begin n_bad++; $display("FAIL frame_clears_underrun: got %b want 0", underrun); end
`ifdef SCANLINE_UNDERRUN_CNT_EN
        n_cmp++; if (underrun_cnt !== 8'd0) begin n_bad++; $display("FAIL frame_clears_cnt: got %0d want 0", underrun_cnt); end
`endif
        tick();
        n_cmp++; if (fill_req !== 1'b1) begin n_bad++; $display("FAIL frame_fill_req: got %b want 1", fill_req); end
        n_cmp++; if (fill_line !== 9'd0) begin n_bad++; $display("FAIL frame_fill_line: got %0d want 0", fill_line); end
        // Frame start that coincides with a refused swap
        line_start  = 1'b1;
        frame_start = 1'b1;
        tick();
        line_start  = 1'b0;
        frame_start = 1'b0;
        n_cmp++; if (underrun !== 1'b1) begin n_bad++; $display("FAIL frame_same_cycle_underrun: got %b want 1", underrun); end
`ifdef SCANLINE_UNDERRUN_CNT_EN
        n_cmp++; if (underrun_cnt !== 8'd1) begin n_bad++; $display("FAIL frame_same_cycle_cnt: got %0d want 1", underrun_cnt); end
`endif
        push(0, 848, 40);
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        tick();
        n_cmp++; if (fill_line !== 9'd0) begin n_bad++; $display("FAIL frame_pending_line: got %0d want 0", fill_line); end
        n_cmp++; if (fill_req !== 1'b1) begin n_bad++; $display("FAIL frame_pending_req: got %b want 1", fill_req); end
    endtask

    task automatic test_reset_mid_fill();
        push(0, 299, 0);
        wr_valid = 1'b1;
        wr_data  = 6'd43;
        #2 RST_N = 1'b0;
        #1;
        n_cmp++; if (wr_ready !== 1'b0) begin n_bad++; $display("FAIL midrst_wr_ready: got %b want 0", wr_ready); end
        n_cmp++; if (fill_req !== 1'b0) begin n_bad++; $display("FAIL midrst_fill_req: got %b want 0", fill_req); end
        n_cmp++; if (fill_line !== 9'd0) begin n_bad++; $display("FAIL midrst_fill_line: got %0d want 0", fill_line); end
        n_cmp++; if (rd_data !== 6'd0) begin n_bad++; $display("FAIL midrst_rd_data: got %0d want 0", rd_data); end
        n_cmp++; if (underrun !== 1'b0) begin n_bad++; $display("FAIL midrst_underrun: got %b want 0", underrun); end
        tick();
        wr_valid = 1'b0;
        RST_N    = 1'b1;
        rd_addr  = 10'd5;
        tick();
        n_cmp++; if (fill_req !== 1'b1) begin n_bad++; $display("FAIL midrst_req_again: got %b want 1", fill_req); end
        n_cmp++; if (fill_line !== 9'd0) begin n_bad++; $display("FAIL midrst_line_again: got %0d want 0", fill_line); end
        n_cmp++; if (rd_data !== 6'd0) begin n_bad++; $display("FAIL midrst_black: got %0d want 0", rd_data); end
    endtask

    initial begin
        test_reset();
        test_fill_swap();
        test_underrun();
        test_back_to_back();
        test_frame_start();
        test_reset_mid_fill();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
